// File: rtl/videogen_param.sv
// Parametrised raster and test-pattern generator: free-running h/v counters,
// frame-latched pattern selection and a single registered output stage.
module videogen_param #(
    parameter int COLOR_W   = 8,
    parameter int H_ACTIVE  = 720,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 62,
    parameter int H_BP      = 60,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 9,
    parameter int V_SYNC    = 6,
    parameter int V_BP      = 30,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int CHK_SHIFT = 4
) (
    input  logic                 clk27,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           pattern_sel,
    input  logic [3*COLOR_W-1:0] solid_rgb,
    output logic [COLOR_W-1:0]   R_out,
    output logic [COLOR_W-1:0]   G_out,
    output logic [COLOR_W-1:0]   B_out,
    output logic                 HSYNC_out,
    output logic                 VSYNC_out,
    output logic                 ENABLE_out,
    output logic                 frame_start
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int BAR_W    = H_ACTIVE / 8;

    logic [HW-1:0]          h_cnt;
    logic [VW-1:0]          v_cnt;
    logic [2:0]             pat_sh;
    logic [3*COLOR_W-1:0]   col_sh;
    logic                   at_origin;
    logic                   active;
    logic                   hs_on;
    logic                   vs_on;
    logic [2:0]             pat_eff;
    logic [3*COLOR_W-1:0]   col_eff;
    logic [3*COLOR_W-1:0]   rgb_next;
    logic [HW-1:0]          bar_q;
    logic [2:0]             bar_sel;
    logic [2:0]             bar_bits;
    logic [HW-1:0]          h_sh;
    logic [VW-1:0]          v_sh;
    logic                   chk_bit;
    logic                   border;
    logic [COLOR_W-1:0]     ramp;

    always_ff @(posedge clk27 or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!enable) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == HW'(H_TOTAL - 1)) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    assign at_origin = (h_cnt == '0) && (v_cnt == '0);

    always_ff @(posedge clk27 or posedge reset) begin
        if (reset) begin
            pat_sh <= '0;
            col_sh <= '0;
        end else if (!enable || at_origin) begin
            pat_sh <= pattern_sel;
            col_sh <= solid_rgb;
        end
    end

    // The first pixel of a frame must already use the selection latched there.
    assign pat_eff = at_origin ? pattern_sel : pat_sh;
    assign col_eff = at_origin ? solid_rgb : col_sh;

    assign active = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
    assign hs_on  = (h_cnt >= HW'(HS_START)) && (h_cnt < HW'(HS_END));
    // VSYNC edges are moved to the HSYNC leading edge of the boundary lines.
    assign vs_on  = ((v_cnt > VW'(VS_START)) ||
                     ((v_cnt == VW'(VS_START)) && (h_cnt >= HW'(HS_START)))) &&
                    ((v_cnt < VW'(VS_END)) ||
                     ((v_cnt == VW'(VS_END)) && (h_cnt < HW'(HS_START))));

    assign bar_q   = h_cnt / HW'(BAR_W);
    assign bar_sel = (bar_q > HW'(7)) ? 3'd7 : bar_q[2:0];
    assign h_sh    = h_cnt >> CHK_SHIFT;
    assign v_sh    = v_cnt >> CHK_SHIFT;
    assign chk_bit = ((h_sh & HW'(1)) != '0) ^ ((v_sh & VW'(1)) != '0);
    assign border  = (h_cnt == '0) || (h_cnt == HW'(H_ACTIVE - 1)) ||
                     (v_cnt == '0) || (v_cnt == VW'(V_ACTIVE - 1));
    assign ramp    = COLOR_W'(h_cnt);

    always_comb begin
        bar_bits = 3'b000;
        case (bar_sel)
            3'd0: bar_bits = 3'b111;
            3'd1: bar_bits = 3'b110;
            3'd2: bar_bits = 3'b011;
            3'd3: bar_bits = 3'b010;
            3'd4: bar_bits = 3'b101;
            3'd5: bar_bits = 3'b100;
            3'd6: bar_bits = 3'b001;
            default: bar_bits = 3'b000;
        endcase
    end

    always_comb begin
        rgb_next = '0;
        case (pat_eff)
            3'd0: rgb_next = col_eff;
            3'd1: rgb_next = {{COLOR_W{bar_bits[2]}}, {COLOR_W{bar_bits[1]}},
                              {COLOR_W{bar_bits[0]}}};
            3'd2: rgb_next = {3*COLOR_W{chk_bit}};
            3'd3: rgb_next = {ramp, ramp, ramp};
            3'd4: rgb_next = {3*COLOR_W{border}};
            default: rgb_next = '0;
        endcase
        if (!active) rgb_next = '0;
    end

    always_ff @(posedge clk27 or posedge reset) begin
        if (reset) begin
            {R_out, G_out, B_out} <= '0;
            ENABLE_out  <= 1'b0;
            frame_start <= 1'b0;
            HSYNC_out   <= ~HS_POL;
            VSYNC_out   <= ~VS_POL;
        end else if (!enable) begin
            {R_out, G_out, B_out} <= '0;
            ENABLE_out  <= 1'b0;
            frame_start <= 1'b0;
            HSYNC_out   <= ~HS_POL;
            VSYNC_out   <= ~VS_POL;
        end else begin
            {R_out, G_out, B_out} <= rgb_next;
            ENABLE_out  <= active;
            frame_start <= at_origin;
            HSYNC_out   <= hs_on ? HS_POL : ~HS_POL;
            VSYNC_out   <= vs_on ? VS_POL : ~VS_POL;
        end
    end

endmodule

// File: tb/tb_videogen_param.sv
// Directed bench for videogen_param on a 24x12 raster; a second instance with
// active-high syncs runs on the same stimulus.
module tb_videogen_param;

    logic        clk27 = 1'b0;
    logic        reset;
    logic        enable;
    logic [2:0]  pattern_sel;
    logic [23:0] solid_rgb;

    logic [7:0]  r_out, g_out, b_out, r2, g2, b2;
    logic        hs, vs, de, fs, hs2, vs2, de2, fs2;

    int tests  = 0;
    int fails  = 0;
    int sh     = 0;
    int sv     = 0;
    int fs_cnt = 0;
    int cyc    = 0;

    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    wire  [23:0] rgb = {r_out, g_out, b_out};

    always #5 clk27 = ~clk27;

    videogen_param #(
        .COLOR_W(8), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CHK_SHIFT(1)
    ) dut (
        .clk27(clk27), .reset(reset), .enable(enable),
        .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
        .R_out(r_out), .G_out(g_out), .B_out(b_out),
        .HSYNC_out(hs), .VSYNC_out(vs), .ENABLE_out(de), .frame_start(fs)
    );

    videogen_param #(
        .COLOR_W(8), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CHK_SHIFT(1)
    ) dut_pos (
        .clk27(clk27), .reset(reset), .enable(enable),
        .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
        .R_out(r2), .G_out(g2), .B_out(b2),
        .HSYNC_out(hs2), .VSYNC_out(vs2), .ENABLE_out(de2), .frame_start(fs2)
    );

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one pixel clock; sh/sv track the raster position on the outputs.
    task automatic step();
        @(negedge clk27);
        if (sh == 23) begin
            sh = 0;
            sv = (sv == 11) ? 0 : sv + 1;
        end else begin
            sh++;
        end
        cyc++;
        if (fs === 1'b1) fs_cnt++;
    endtask

    task automatic goto_px(input int v, input int h);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(sv == v && sh == h) && n < 400);
        if (n >= 400) begin
            tests++;
            fails++;
            $error("FAIL goto_timeout: observed v%0d h%0d expected v%0d h%0d", sv, sh, v, h);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        pattern_sel = 3'd1;
        solid_rgb   = 24'h0;
        repeat (3) @(negedge clk27);

        chk("rst_rgb", rgb, 24'h0);
        chk("rst_de", 24'(de), 24'h0);
        chk("rst_fs", 24'(fs), 24'h0);
        chk("rst_hs", 24'(hs), 24'h1);
        chk("rst_vs", 24'(vs), 24'h1);
        chk("rst_hs_pos", 24'(hs2), 24'h0);
        chk("rst_vs_pos", 24'(vs2), 24'h0);

        // Frame 0: colour bars, full line 0 timing.
        reset  = 1'b0;
        enable = 1'b1;
        sh = 23; sv = 11;
        for (int h = 0; h < 24; h++) begin
            step();
            chk("l0_rgb", rgb, (h < 16) ? bars[h / 2] : 24'h0);
            chk("l0_de", 24'(de), (h < 16) ? 24'h1 : 24'h0);
            chk("l0_hs", 24'(hs), (h >= 18 && h < 21) ? 24'h0 : 24'h1);
            chk("l0_vs", 24'(vs), 24'h1);
            chk("l0_fs", 24'(fs), (h == 0) ? 24'h1 : 24'h0);
        end
        chk("l0_hs_pos", 24'(hs2), 24'h0);
        goto_px(1, 18);
        chk("l1_hs_pos", 24'(hs2), 24'h1);
        chk("l1_hs", 24'(hs), 24'h0);

        // Vertical sync window, and a mid-frame pattern change.
        goto_px(9, 17);
        pattern_sel = 3'd0;
        solid_rgb   = 24'h123456;
        chk("vs_9_17", 24'(vs), 24'h1);
        step();
        chk("vs_9_18", 24'(vs), 24'h0);
        chk("hs_9_18", 24'(hs), 24'h0);
        goto_px(10, 5);
        chk("vs_10_5", 24'(vs), 24'h0);
        chk("vs_10_5_pos", 24'(vs2), 24'h1);
        goto_px(11, 17);
        chk("vs_11_17", 24'(vs), 24'h0);
        step();
        chk("vs_11_18", 24'(vs), 24'h1);

        // Frame 1: solid colour; switch to ramp at line 4.
        goto_px(0, 0);
        chk("f1_fs", 24'(fs), 24'h1);
        chk("f1_rgb_0_0", rgb, 24'h123456);
        fs_cnt = 0;
        cyc    = 0;
        goto_px(2, 7);
        chk("f1_rgb_2_7", rgb, 24'h123456);
        goto_px(4, 0);
        chk("f1_rgb_4_0", rgb, 24'h123456);
        pattern_sel = 3'd3;
        goto_px(4, 5);
        chk("f1_rgb_4_5", rgb, 24'h123456);
        goto_px(7, 15);
        chk("f1_rgb_7_15", rgb, 24'h123456);

        // Frame 2: ramp.
        goto_px(0, 0);
        chk("fs_period", 24'(cyc), 24'd288);
        chk("fs_count", 24'(fs_cnt), 24'd1);
        chk("f2_rgb_0_0", rgb, 24'h000000);
        goto_px(0, 15);
        chk("f2_rgb_0_15", rgb, 24'h0F0F0F);
        step();
        chk("f2_rgb_0_16", rgb, 24'h000000);
        goto_px(1, 0);
        pattern_sel = 3'd2;
        goto_px(3, 10);
        chk("f2_rgb_3_10", rgb, 24'h0A0A0A);

        // Frame 3: checkerboard with 2x2 squares.
        goto_px(0, 0);
        chk("f3_rgb_0_0", rgb, 24'h000000);
        step();
        chk("f3_rgb_0_1", rgb, 24'h000000);
        step();
        chk("f3_rgb_0_2", rgb, 24'hFFFFFF);
        goto_px(1, 3);
        chk("f3_rgb_1_3", rgb, 24'hFFFFFF);
        goto_px(2, 0);
        chk("f3_rgb_2_0", rgb, 24'hFFFFFF);
        goto_px(2, 2);
        chk("f3_rgb_2_2", rgb, 24'h000000);
        goto_px(3, 0);
        pattern_sel = 3'd4;

        // Frame 4: border.
        goto_px(0, 0);
        chk("f4_rgb_0_0", rgb, 24'hFFFFFF);
        goto_px(0, 7);
        chk("f4_rgb_0_7", rgb, 24'hFFFFFF);
        goto_px(3, 0);
        chk("f4_rgb_3_0", rgb, 24'hFFFFFF);
        goto_px(3, 7);
        chk("f4_rgb_3_7", rgb, 24'h000000);
        goto_px(3, 15);
        chk("f4_rgb_3_15", rgb, 24'hFFFFFF);
        goto_px(7, 7);
        chk("f4_rgb_7_7", rgb, 24'hFFFFFF);
        goto_px(7, 16);
        chk("f4_rgb_7_16", rgb, 24'h000000);
        goto_px(8, 0);
        chk("f4_rgb_8_0", rgb, 24'h000000);

        // Asynchronous reset with the counters at h=7, v=5.
        goto_px(5, 6);
        chk("pre_rst_de", 24'(de), 24'h1);
        reset = 1'b1;
        #1;
        chk("arst_de", 24'(de), 24'h0);
        chk("arst_fs", 24'(fs), 24'h0);
        chk("arst_hs", 24'(hs), 24'h1);
        chk("arst_vs", 24'(vs), 24'h1);
        chk("arst_hs_pos", 24'(hs2), 24'h0);
        @(negedge clk27);
        chk("rst_hold_de", 24'(de), 24'h0);
        reset = 1'b0;
        sh = 23; sv = 11;
        step();
        chk("post_rst_fs", 24'(fs), 24'h1);
        chk("post_rst_de", 24'(de), 24'h1);
        chk("post_rst_rgb", rgb, 24'hFFFFFF);

        // Enable dropped for 50 cycles just before the HSYNC pulse.
        goto_px(2, 17);
        enable      = 1'b0;
        pattern_sel = 3'd1;
        @(negedge clk27);
        chk("dis_de", 24'(de), 24'h0);
        chk("dis_rgb", rgb, 24'h0);
        chk("dis_hs", 24'(hs), 24'h1);
        chk("dis_vs", 24'(vs), 24'h1);
        chk("dis_fs", 24'(fs), 24'h0);
        chk("dis_hs_pos", 24'(hs2), 24'h0);
        repeat (49) @(negedge clk27);
        chk("dis_end_de", 24'(de), 24'h0);
        enable = 1'b1;
        sh = 23; sv = 11;
        step();
        chk("reen_fs", 24'(fs), 24'h1);
        chk("reen_de", 24'(de), 24'h1);
        chk("reen_rgb_0", rgb, 24'hFFFFFF);
        goto_px(0, 2);
        chk("reen_rgb_2", rgb, 24'hFFFF00);
        goto_px(0, 15);
        chk("reen_rgb_15", rgb, 24'h000000);
        chk("reen_de_15", 24'(de), 24'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
